// File: rtl/semaphore_pool_rr.sv
// semaphore_pool_rr: pool of independent counting semaphores shared by several
// cores. Each semaphore grants at most one acquire per cycle through its own
// round-robin pointer, sums all releases from the cores in the same cycle,
// saturates at the top count and raises a sticky overflow flag when it does.
module semaphore_pool_rr #(
  parameter int NumberOfSemaphores = 4,
  parameter int NumberOfCores      = 2,
  parameter int CountWidth         = 4,
  parameter int InitCount          = 1
) (
  input  logic                                         CLK,
  input  logic                                         SEMAPHOREPOOL_RESET_N,
  input  logic [NumberOfSemaphores*NumberOfCores-1:0]  SEMAPHOREPOOL_ACQ,
  input  logic [NumberOfSemaphores*NumberOfCores-1:0]  SEMAPHOREPOOL_REL,
  output logic [NumberOfSemaphores*NumberOfCores-1:0]  SEMAPHOREPOOL_GNT,
  output logic [NumberOfSemaphores*NumberOfCores-1:0]  SEMAPHOREPOOL_BLOCKING,
  input  logic [NumberOfSemaphores-1:0]                SEMAPHOREPOOL_WR,
  input  logic [CountWidth*NumberOfSemaphores-1:0]     SEMAPHOREPOOL_CntIn,
  output logic [CountWidth*NumberOfSemaphores-1:0]     SEMAPHOREPOOL_CntOut,
  output logic [NumberOfSemaphores-1:0]                SEMAPHOREPOOL_OVF
);

  localparam int S    = NumberOfSemaphores;
  localparam int C    = NumberOfCores;
  localparam int W    = CountWidth;
  localparam int IdxW = $clog2(C);
  // Wide enough to hold MaxCount plus C simultaneous releases without wrapping.
  localparam int SumW = W + $clog2(C) + 1;

  localparam logic [SumW-1:0] MaxCount = SumW'({W{1'b1}});

  logic [S-1:0][W-1:0]    cnt_q, cnt_d;
  logic [S-1:0]           ovf_q, ovf_d;
  logic [S*C-1:0]         gnt_q, gnt_d;
  logic [S*C-1:0]         blk_q, blk_d;
  logic [S-1:0][IdxW-1:0] ptr_q, ptr_d;

  // Per semaphore: load, or round-robin arbitration plus saturating count update.
  always_comb begin : next_state
    logic            found;
    logic            grant;
    int              win;
    int              idx;
    logic [SumW-1:0] rel_sum;
    logic [SumW-1:0] next_cnt;
    // NOTE: every combinational output is given a default before any branch,
    // so no path leaves a signal unassigned and no latch is inferred.
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    gnt_d    = '0;
    ptr_d    = ptr_q;
    found    = 1'b0;
    grant    = 1'b0;
    win      = 0;
    idx      = 0;
    rel_sum  = '0;
    next_cnt = '0;
    for (int s = 0; s < S; s++) begin
      // Scan upward from the pointer; a core granted last cycle is masked so
      // it can drop its request without being granted twice.
      found = 1'b0;
      win   = 0;
      for (int i = 0; i < C; i++) begin
        idx = (int'(ptr_q[s]) + i) % C;
        if (!found && SEMAPHOREPOOL_ACQ[idx*S+s] && !gnt_q[idx*S+s]) begin
          found = 1'b1;
          win   = idx;
        end
      end

      rel_sum = '0;
      for (int c = 0; c < C; c++) begin
        rel_sum = rel_sum + SumW'(SemRel(c, s));
      end

      if (SEMAPHOREPOOL_WR[s]) begin
        cnt_d[s] = SEMAPHOREPOOL_CntIn[W*s +: W];
        ovf_d[s] = 1'b0;
      end else begin
        // Eligibility looks at the registered count only, so a release in the
        // same cycle as an empty semaphore cannot fund a grant until next cycle.
        grant = found && (cnt_q[s] != '0);
        if (grant) begin
          gnt_d[win*S+s] = 1'b1;
          ptr_d[s]       = IdxW'((win + 1) % C);
        end
        next_cnt = SumW'(cnt_q[s]) - SumW'(grant) + rel_sum;
        if (next_cnt > MaxCount) begin
          cnt_d[s] = {W{1'b1}};
          ovf_d[s] = 1'b1;
        end else begin
          cnt_d[s] = next_cnt[W-1:0];
        end
      end
    end
    blk_d = SEMAPHOREPOOL_ACQ & ~gnt_d;
  end

  function automatic logic SemRel(input int c, input int s);
    return SEMAPHOREPOOL_REL[c*S+s];
  endfunction

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    if (!SEMAPHOREPOOL_RESET_N) begin
      cnt_q <= {S{W'(InitCount)}};
      ovf_q <= '0;
      gnt_q <= '0;
      blk_q <= '0;
      ptr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      gnt_q <= gnt_d;
      blk_q <= blk_d;
      ptr_q <= ptr_d;
    end
  end

  assign SEMAPHOREPOOL_GNT      = gnt_q;
  assign SEMAPHOREPOOL_BLOCKING = blk_q;
  assign SEMAPHOREPOOL_CntOut   = cnt_q;
  assign SEMAPHOREPOOL_OVF      = ovf_q;

endmodule
